// File: rtl/mem_req_arbiter_pkg.sv
// Shared memory-message definitions: opcode constants and field-width helpers
// used by the request/response message structs.
package mem_req_arbiter_pkg;

    localparam int MEM_OP_BITS = 3;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_READ  = 3'd0;
    localparam logic [MEM_OP_BITS-1:0] MEM_OP_WRITE = 3'd1;

    // len encodes the access size in bytes minus one, so it needs log2 of the data bytes.
    function automatic int mem_len_bits(input int data_bits);
        return (data_bits > 8) ? $clog2(data_bits / 8) : 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester-side and memory-side val/rdy channels shared by the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface mem_req_arbiter_if #(
    parameter int p_num_req   = 2,
    parameter int p_opaq_bits = 8,
    parameter int p_addr_bits = 32,
    parameter int p_data_bits = 32
);
    import mem_req_arbiter_pkg::*;

    localparam int LenBits = mem_len_bits(p_data_bits);

    typedef struct packed {
        logic [MEM_OP_BITS-1:0] op;
        logic [p_opaq_bits-1:0] opaque;
        logic [p_addr_bits-1:0] addr;
        logic [LenBits-1:0]     len;
        logic [p_data_bits-1:0] data;
    } req_msg_t;

    typedef struct packed {
        logic [MEM_OP_BITS-1:0] op;
        logic [p_opaq_bits-1:0] opaque;
        logic [LenBits-1:0]     len;
        logic [p_data_bits-1:0] data;
    } resp_msg_t;

    logic [p_num_req-1:0]     req_val;
    logic [p_num_req-1:0]     req_rdy;
    req_msg_t [p_num_req-1:0] req_msg;

    logic     mem_req_val;
    logic     mem_req_rdy;
    req_msg_t mem_req_msg;

    logic      mem_resp_val;
    logic      mem_resp_rdy;
    resp_msg_t mem_resp_msg;

    logic [p_num_req-1:0] resp_val;
    logic [p_num_req-1:0] resp_rdy;
    resp_msg_t            resp_msg;

    modport slave (
        input  req_val, req_msg, mem_req_rdy, mem_resp_val, mem_resp_msg, resp_rdy,
        output req_rdy, mem_req_val, mem_req_msg, mem_resp_rdy, resp_val, resp_msg
    );

    modport master (
        output req_val, req_msg, mem_req_rdy, mem_resp_val, mem_resp_msg, resp_rdy,
        input  req_rdy, mem_req_val, mem_req_msg, mem_resp_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// Power-of-two deep synchronous FIFO with full/empty/head outputs and no bypass:
// a push into a full FIFO is dropped even when a pop happens in the same cycle.
module mem_arb_id_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int p_width = 1,
    parameter int p_depth = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enq_en,
    input  logic [p_width-1:0] enq_data,
    input  logic               deq_en,
    output logic               full,
    output logic               empty,
    output logic [p_width-1:0] head
);

    localparam int AddrBits = $clog2(p_depth);

    logic [p_width-1:0]  slots [p_depth];
    logic [AddrBits-1:0] wr_ptr;
    logic [AddrBits-1:0] rd_ptr;
    logic [AddrBits:0]   count;
    logic                do_enq;
    logic                do_deq;

    assign full   = (count == (AddrBits+1)'(p_depth));
    assign empty  = (count == '0);
    assign head   = slots[rd_ptr];
    assign do_enq = enq_en && !full;
    assign do_deq = deq_en && !empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            slots[wr_ptr] <= enq_data;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port between requesters; granted IDs are
// queued in order so in-order responses can be steered back with zero added latency.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int p_num_req         = 2,
    parameter int p_max_outstanding = 4
) (
    input  logic clk,
    input  logic rst_n,
    mem_req_arbiter_if.slave bus
);

    localparam int IdBits = $clog2(p_num_req);

    logic [IdBits-1:0] prio_ptr;
    logic [IdBits-1:0] locked_id;
    logic              lock;
    logic [IdBits-1:0] rr_pick;
    logic              rr_found;
    logic [IdBits-1:0] cand_id;
    logic [IdBits-1:0] grant;
    logic [IdBits-1:0] next_ptr;
    logic [IdBits-1:0] head_id;
    logic              id_full;
    logic              id_empty;
    logic              req_fire;
    logic              resp_fire;

    // First valid requester at or after prio_ptr, wrapping; independent of mem_req_rdy.
    always_comb begin
        rr_pick  = prio_ptr;
        rr_found = 1'b0;
        cand_id  = '0;
        for (int k = 0; k < p_num_req; k++) begin
            cand_id = IdBits'((int'(prio_ptr) + k) % p_num_req);
            if (!rr_found && bus.req_val[cand_id]) begin
                rr_pick  = cand_id;
                rr_found = 1'b1;
            end
        end
    end

    assign grant     = lock ? locked_id : rr_pick;
    assign next_ptr  = (grant == IdBits'(p_num_req - 1)) ? '0 : grant + 1'b1;

    assign bus.mem_req_val = (|bus.req_val) && !id_full;
    assign bus.mem_req_msg = bus.req_msg[grant];
    assign req_fire        = bus.mem_req_val && bus.mem_req_rdy;

    always_comb begin
        bus.req_rdy = '0;
        for (int i = 0; i < p_num_req; i++) begin
            if ((grant == IdBits'(i)) && bus.mem_req_rdy && !id_full) begin
                bus.req_rdy[i] = 1'b1;
            end
        end
    end

    // A stalled request pins the grant so mem_req_msg stays stable until it fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr  <= '0;
            lock      <= 1'b0;
            locked_id <= '0;
        end else if (req_fire) begin
            prio_ptr <= next_ptr;
            lock     <= 1'b0;
        end else if (bus.mem_req_val) begin
            lock      <= 1'b1;
            locked_id <= grant;
        end
    end

    mem_arb_id_fifo #(
        .p_width (IdBits),
        .p_depth (p_max_outstanding)
    ) id_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq_en   (req_fire),
        .enq_data (grant),
        .deq_en   (resp_fire),
        .full     (id_full),
        .empty    (id_empty),
        .head     (head_id)
    );

    assign bus.resp_msg     = bus.mem_resp_msg;
    assign bus.mem_resp_rdy = !id_empty && bus.resp_rdy[head_id];
    assign resp_fire        = bus.mem_resp_val && bus.mem_resp_rdy;

    always_comb begin
        bus.resp_val = '0;
        for (int i = 0; i < p_num_req; i++) begin
            if (bus.mem_resp_val && !id_empty && (head_id == IdBits'(i))) begin
                bus.resp_val[i] = 1'b1;
            end
        end
    end

endmodule
